wide_add_sequencer: RTL and testbench



---
 rtl/wide_add_sequencer.sv | 106 ++++++++++
 tb/tb_wide_add_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wide_add_sequencer.sv
// Purpose: WORD_W-bit add/subtract built by stepping an external 4-bit adder one nibble per cycle, LSB first.
// Latency: start accepted at edge 0, busy for NIBBLES cycles, done pulses in cycle NIBBLES+1.
// Backpressure: none; start_in is honoured only in IDLE or DONE and ignored while busy.
module wide_add_sequencer #(
  parameter int WORD_W  = 16,
  parameter int NIBBLES = WORD_W / 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_in,
  input  logic              sub_in,
  input  logic [WORD_W-1:0] a_in,
  input  logic [WORD_W-1:0] b_in,
  input  logic              c_in,
  output logic [3:0]        add_a,
  output logic [3:0]        add_b,
  output logic              add_cin,
  input  logic [3:0]        add_sum,
  input  logic              add_cout,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] result,
  output logic              carry_out,
  output logic              overflow
);

  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);
  localparam int MSB = WORD_W - 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [WORD_W-1:0] a_reg;
  logic [WORD_W-1:0] b_reg;   // already inverted for subtract
  logic              carry_reg;
  logic              sub_reg;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W+1:0]  bit_base;

  // Bit offset of the nibble currently being processed.
  assign bit_base = {idx, 2'b00};

  // Present the current nibble pair and ripple carry to the adder; quiet outside RUN.
  always_comb begin
    add_a   = 4'h0;
    add_b   = 4'h0;
    add_cin = 1'b0;
    if (state == RUN) begin
      add_a   = a_reg[bit_base +: 4];
      add_b   = b_reg[bit_base +: 4];
      add_cin = carry_reg;
    end
  end

  // Sequencer FSM: latch operands, collect one adder nibble per cycle, publish flags on entry to DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      carry_reg <= 1'b0;
      sub_reg   <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start_in) begin
            // Subtract is a + ~b + ~borrow, so the borrow-in is inverted into the carry.
            a_reg     <= a_in;
            b_reg     <= sub_in ? ~b_in : b_in;
            carry_reg <= c_in ^ sub_in;
            sub_reg   <= sub_in;
            idx       <= '0;
            busy      <= 1'b1;
            state     <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          result[bit_base +: 4] <= add_sum;
          carry_reg             <= add_cout;
          idx                   <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            idx       <= '0;
            busy      <= 1'b0;
            done      <= 1'b1;
            // Final adder carry is the borrow complement when subtracting.
            carry_out <= add_cout ^ sub_reg;
            overflow  <= (a_reg[MSB] == b_reg[MSB]) && (add_sum[3] != a_reg[MSB]);
            state     <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Purpose: self-checking bench for wide_add_sequencer with a behavioural 4-bit adder alongside.
// Latency: expects done exactly NIBBLES+1 cycles after the start edge.
// Backpressure: exercises held start, mid-run reset and back-to-back starts.
module tb_wide_add_sequencer;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start_in;
  logic         sub_in;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         c_in;
  logic [3:0]   add_a;
  logic [3:0]   add_b;
  logic         add_cin;
  logic [3:0]   add_sum;
  logic         add_cout;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         carry_out;
  logic         overflow;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  // External combinational nibble adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {4'b0, add_cin};

  wide_add_sequencer #(.WORD_W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_in  (start_in),
    .sub_in    (sub_in),
    .a_in      (a_in),
    .b_in      (b_in),
    .c_in      (c_in),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_cin   (add_cin),
    .add_sum   (add_sum),
    .add_cout  (add_cout),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic         sub;
    logic [W-1:0] er;
    logic         ec;
    logic         eo;
    logic [3:0]   ecins;
  } vec_t;

  vec_t vecs[7];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference: plain integer arithmetic on the operands, returns {overflow, carry/borrow, result}.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c, input logic sub);
    int           sa;
    int           sb;
    int           sr;
    logic [W:0]   full;
    logic [W-1:0] r;
    logic         cy;
    logic         ov;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (!sub) begin
      full = {1'b0, a} + {1'b0, b} + (W+1)'(c);
      r    = full[W-1:0];
      cy   = full[W];
      sr   = sa + sb + int'(c);
    end else begin
      r  = a - b - W'(c);
      cy = ({1'b0, a} < ({1'b0, b} + (W+1)'(c)));
      sr = sa - sb - int'(c);
    end
    ov = (sr > 32767) || (sr < -32768);
    return {ov, cy, r};
  endfunction

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic sub);
    a_in     = a;
    b_in     = b;
    c_in     = c;
    sub_in   = sub;
    start_in = 1'b1;
  endtask

  // Consume the start edge, follow the run to done (bounded) and compare everything.
  task automatic finish_op(input string nm, input bit hold, input logic [W-1:0] er,
                           input logic ec, input logic eo, input bit chk_cins, input logic [3:0] ecins);
    int         lat;
    int         k;
    logic [3:0] cins;
    tick;
    if (!hold) start_in = 1'b0;
    check({nm, "_busy1"}, busy, 1);
    lat  = 1;
    k    = 0;
    cins = 4'h0;
    while (!done && lat < 20) begin
      if (busy && k < 4) begin
        cins[k] = add_cin;
        k++;
      end
      if (hold) begin
        a_in = W'($urandom);
        b_in = W'($urandom);
        if (lat == NIB) start_in = 1'b0;
      end
      tick;
      lat++;
    end
    check({nm, "_done"}, done, 1);
    check({nm, "_latency"}, lat, NIB + 1);
    check({nm, "_busy_in_done"}, busy, 0);
    check({nm, "_result"}, result, er);
    check({nm, "_carry"}, carry_out, ec);
    check({nm, "_ovf"}, overflow, eo);
    if (chk_cins) check({nm, "_cins"}, cins, ecins);
  endtask

  initial begin
    logic [W+1:0] m;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic         rs;
    bit           seen;

    vecs[0] = '{16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 4'b0000};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 4'b1110};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 4'b1110};
    vecs[3] = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b1, 1'b0, 4'b0001};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1, 4'b0001};
    vecs[5] = '{16'h0010, 16'h0001, 1'b1, 1'b1, 16'h000E, 1'b0, 1'b0, 4'b1100};
    vecs[6] = '{16'h000F, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0, 4'b0011};

    rst_n    = 1'b0;
    start_in = 1'b0;
    sub_in   = 1'b0;
    a_in     = '0;
    b_in     = '0;
    c_in     = 1'b0;

    // Reset held for three cycles.
    repeat (3) tick;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_result", result, 0);
    check("rst_carry", carry_out, 0);
    check("rst_ovf", overflow, 0);
    check("rst_add_a", add_a, 0);
    check("rst_add_b", add_b, 0);
    check("rst_add_cin", add_cin, 0);
    rst_n = 1'b1;
    repeat (3) tick;
    check("idle_busy", busy, 0);
    check("idle_done", done, 0);

    // Directed vectors.
    for (int i = 0; i < 7; i++) begin
      launch(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].sub);
      finish_op($sformatf("vec%0d", i), 1'b0, vecs[i].er, vecs[i].ec, vecs[i].eo, 1'b1, vecs[i].ecins);
      tick;
      check($sformatf("vec%0d_done_drop", i), done, 0);
    end

    // start held through RUN with changing operands.
    launch(16'h1234, 16'h4321, 1'b0, 1'b0);
    finish_op("hold", 1'b1, 16'h5555, 1'b0, 1'b0, 1'b1, 4'b0000);
    tick;
    check("hold_idle_busy", busy, 0);

    // Reset in the second RUN cycle aborts with no done.
    launch(16'hAAAA, 16'h5555, 1'b0, 1'b0);
    tick;
    start_in = 1'b0;
    tick;
    check("abort_running", busy, 1);
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    check("abort_busy", busy, 0);
    check("abort_result", result, 0);
    check("abort_add_a", add_a, 0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (done) seen = 1'b1;
      tick;
    end
    check("abort_no_done", seen, 0);
    launch(16'h0F0F, 16'h00F1, 1'b0, 1'b0);
    finish_op("after_abort", 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1, 4'b1110);
    tick;

    // Back-to-back: second start during the DONE cycle.
    launch(16'h1111, 16'h2222, 1'b0, 1'b0);
    finish_op("b2b1", 1'b0, 16'h3333, 1'b0, 1'b0, 1'b1, 4'b0000);
    launch(16'h0005, 16'h0007, 1'b0, 1'b1);
    finish_op("b2b2", 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b1, 4'b0001);
    tick;

    // Random operations against the arithmetic model, some back-to-back.
    for (int i = 0; i < 40; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      m  = model(ra, rb, rc, rs);
      launch(ra, rb, rc, rs);
      finish_op($sformatf("rnd%0d", i), 1'b0, m[W-1:0], m[W], m[W+1], 1'b0, 4'h0);
      if ($urandom_range(0, 1) == 0) tick;
    end
    tick;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
